// File: rtl/mean_pkg.sv
// Shared constants, FSM encoding and elaboration helpers for the streaming mean block.
package mean_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time widths; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

  // Bias added before the final shift: half an LSB of the mean when rounding.
  function automatic int round_bias(input int log2n, input int round_mode);
    if (round_mode == ROUND_HALF_UP && log2n > 0) return 1 << (log2n - 1);
    return 0;
  endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// Combinational reduction of LANES unsigned samples to a single full-width sum.
module lane_adder_tree
  import mean_pkg::*;
#(
  parameter  int LANES = 8,
  parameter  int WID   = 16,
  localparam int SUM_W = WID + clog2(LANES)
) (
  input  logic [LANES*WID-1:0] data_i,
  output logic [SUM_W-1:0]     sum_o
);

  // Heap-ordered tree: leaves at LANES-1 .. 2*LANES-2, node i sums children 2i+1 and 2i+2.
  logic [SUM_W-1:0] node [2*LANES-1];

  // Load the leaves, then fold pairs upward so every node is assigned on every pass.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      node[LANES-1+i] = SUM_W'(data_i[i*WID +: WID]);
    end
    for (int i = LANES - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
  end

  assign sum_o = node[0];

endmodule

// File: rtl/mean_stream.sv
// Streaming frame mean: beats of LANES samples are tree-reduced, accumulated over a
// frame, then the frame sum and its (truncated or rounded) mean are held for the consumer.
module mean_stream
  import mean_pkg::*;
#(
  parameter int NUM_INPUTS = 128,
  parameter int WID        = 16,
  parameter int LANES      = 8,
  parameter int ROUND      = ROUND_HALF_UP
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*WID-1:0]          in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WID+clog2(NUM_INPUTS)-1:0] out_sum,
  output logic [WID-1:0]                out_mean
);

  localparam int LOG2N  = clog2(NUM_INPUTS);
  localparam int LOG2L  = clog2(LANES);
  localparam int BEATS  = NUM_INPUTS / LANES;
  localparam int CNT_W  = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam int SUM_W  = WID + LOG2N;
  localparam int LANE_W = WID + LOG2L;
  localparam int BIAS   = round_bias(LOG2N, ROUND);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic               lane_v_q, lane_v_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [WID-1:0]     mean_q, mean_d;
  logic               rdy_q, rdy_d;

  logic [LANE_W-1:0]  lane_sum;
  logic [SUM_W-1:0]   acc_plus;
  logic [SUM_W:0]     rounded;
  logic               fire_in;
  logic               last_beat;

  lane_adder_tree #(
    .LANES (LANES),
    .WID   (WID)
  ) u_tree (
    .data_i (in_data),
    .sum_o  (lane_sum)
  );

  assign fire_in   = in_valid && rdy_q;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign acc_plus  = acc_q + (lane_v_q ? SUM_W'(lane_q) : '0);
  // One spare bit keeps the rounding bias from wrapping before the shift.
  assign rounded   = {1'b0, acc_plus} + (SUM_W+1)'(BIAS);

  // Next-state decode for the frame FSM, beat counter, pipeline and result registers.
  always_comb begin
    // NOTE: every _d gets a default here so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    lane_v_d = 1'b0;
    acc_d    = acc_plus;
    sum_d    = sum_q;
    mean_d   = mean_q;
    unique case (state_q)
      ACCUM: begin
        if (fire_in) begin
          lane_d   = lane_sum;
          lane_v_d = 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        sum_d   = acc_plus;
        mean_d  = WID'(rounded >> LOG2N);
        acc_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    rdy_d = (state_d == ACCUM);
  end

  // State update with synchronous active-low reset; a reset discards any partial frame or result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q  <= ACCUM;
      cnt_q    <= '0;
      lane_q   <= '0;
      lane_v_q <= 1'b0;
      acc_q    <= '0;
      sum_q    <= '0;
      mean_q   <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      lane_v_q <= lane_v_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      mean_q   <= mean_d;
      rdy_q    <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_mean  = mean_q;

endmodule

// File: doc/mean_stream.md
# mean_stream

Parametrised streaming successor to the fixed 128-input mean block. Accepts a frame of NUM_INPUTS unsigned samples as NUM_INPUTS/LANES beats over a valid/ready stream. Each beat's lanes are reduced through a registered adder tree into a frame accumulator. Emits the frame sum and its mean, truncated or rounded, on a held valid/ready output. It sits between sample producers and downstream statistics logic, replacing the wide all-parallel mean wherever input bandwidth is limited.

## Interface
- NUM_INPUTS, 128, samples per frame; power of two, ≥ LANES
- WID, 16, unsigned sample width
- LANES, 8, samples per beat; power of two, divides NUM_INPUTS
- ROUND, 1, 0 = truncate, 1 = round half up
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  beat present
- in_ready  out  1  block can take a beat
- in_data  in  LANES*WID  lane i at bits [i*WID +: WID]
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_sum  out  WID+LOG2N  full frame sum, LOG2N = clog2(NUM_INPUTS)
- out_mean  out  WID  mean per ROUND

## Operation
- Derived constants: BEATS = NUM_INPUTS/LANES and LOG2L = clog2(LANES).
- Beat handshake: in_valid && in_ready at a rising edge.
- FSM:
  - ACCUM: in_ready=1. Each handshake registers the lane sum (WID+LOG2L bits) into lane_q with lane_v=1. A registered lane_q is added into acc.
  - Beat counter runs 0..BEATS-1. The handshake at count BEATS-1 moves the FSM to FLUSH and wraps the counter to 0.
  - FLUSH: in_ready=0. Adds the final lane_q, loads out_sum and out_mean, clears acc and moves to HOLD.
  - HOLD: in_ready=0, out_valid=1. out_valid && out_ready returns the FSM to ACCUM.
- Arithmetic:
  - acc is WID+LOG2N bits and never overflows.
  - out_mean = (sum + ROUND·2^(LOG2N-1)) >> LOG2N, computed at WID+LOG2N+1 bits. The result always fits in WID bits, so no saturation is needed.
- in_valid gaps inside a frame are legal. The counter and acc hold and lane_v drops to 0.
- LANES == NUM_INPUTS gives BEATS=1: every handshake is a last beat.
- in_data while in_valid=0 is ignored.
- Reset (rst_n=0 at an edge) from any state, including mid-frame or mid-HOLD:
  - FSM → ACCUM; counter, acc, lane_q and lane_v cleared.
  - Any partial frame or pending result is discarded.
  - in_ready=0 during reset. out_valid=0, out_sum=0 and out_mean=0.

## Timing
- Latency: last-beat handshake at edge E. lane_q is registered at E, the result is loaded at E+1, and out_valid is high from E+1 onward.
- Throughput: one beat per cycle within a frame. Between frames there is a minimum 2-cycle in_ready bubble: the FLUSH cycle plus one cycle of HOLD. in_ready is high again in the cycle after the output handshake.
- out_sum and out_mean are stable while out_valid=1 && out_ready=0.
- out_ready is don't-care when out_valid=0.
- in_valid may be asserted while in_ready=0. No beat is taken and the producer holds in_data.
- There is no combinational path from in_valid or out_ready to any output. in_ready is a decode of the FSM register only.

## Structure
- Package mean_pkg:
  - clog2 function
  - ROUND_TRUNC=0 and ROUND_HALF_UP=1 constants
  - FSM state encoding: ACCUM, FLUSH, HOLD
- Sub-module lane_adder_tree (params LANES, WID) is a purely combinational reduction of in_data to a WID+LOG2L sum. It is registered in mean_stream, and the same tree is reusable for other parallel-reduction blocks.
- Top-level mean_stream holds the FSM, beat counter, accumulator, divide/round and output registers.

## Test plan
- Ramp frame, defaults, ROUND=1: 16 beats of samples 0..127 in order, out_ready=1 → out_sum=8128, out_mean=64, out_valid 1 cycle after the last-beat edge. Repeat with ROUND=0 → out_mean=63.
- Max values: all samples 0xFFFF, ROUND=1 → out_sum=0x7FFF80, out_mean=0xFFFF (no wrap).
- Ramp+1 series: 100 back-to-back frames with every sample incremented by 1 per frame, k=0..99 → each result has out_sum=8128+128k and out_mean=64+k (ROUND=1). in_ready drops for exactly 2 cycles between frames.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD → out_valid, out_sum and out_mean are stable, in_ready=0 and in_valid beats are not taken. Release → next frame accepted in the cycle after the output handshake.
- Bubbles and reset: insert random in_valid gaps → same results as gap-free. Reset for 1 cycle after 7 beats, then send 16 beats of value 5 → out_sum=640, out_mean=5, with no residue from the aborted frame.
- Config LANES=128, NUM_INPUTS=128: single beat of 0..127 → out_mean=64. Config LANES=1, NUM_INPUTS=4: beats 1,2,3,3 with ROUND=1 → out_sum=9, out_mean=2.
